// File: rtl/fence_pkg.sv
// Shared constants and types for the fence host: default frame geometry, FSM state
// encodings and the {x,y} point record.
package fence_pkg;

   localparam int NPTS_DEF = 6;
   localparam int W_DEF    = 8;

   localparam logic [2:0] S_LOAD  = 3'd0;
   localparam logic [2:0] S_SEND  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CAPT  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   typedef enum logic [2:0] {
      LOAD  = S_LOAD,
      SEND  = S_SEND,
      WAIT  = S_WAIT,
      CAPT  = S_CAPT,
      DRAIN = S_DRAIN
   } fence_state_e;

   typedef struct packed {
      logic [W_DEF-1:0] x;
      logic [W_DEF-1:0] y;
   } point_t;

endpackage

// File: rtl/fence_pt_buf.sv
// DEPTH-entry {x,y} register file: one synchronous write port, one combinational read port.
// Out-of-range read addresses return zero so callers may present idx+1 at the frame end.
module fence_pt_buf import fence_pkg::*; #(
   parameter int DEPTH = NPTS_DEF,
   parameter int W     = W_DEF,
   parameter int AW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wx,
   input  logic [W-1:0]  wy,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rx,
   output logic [W-1:0]  ry
);

   logic [W-1:0] mem_x [DEPTH];
   logic [W-1:0] mem_y [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_x[i] <= '0;
            mem_y[i] <= '0;
         end
      end else if (we && (waddr < AW'(DEPTH))) begin
         mem_x[waddr] <= wx;
         mem_y[waddr] <= wy;
      end
   end

   always_comb begin
      rx = '0;
      ry = '0;
      if (raddr < AW'(DEPTH)) begin
         rx = mem_x[raddr];
         ry = mem_y[raddr];
      end
   end

endmodule

// File: rtl/fence_host.sv
// Fence host: loads a frame of points, streams it to the engine, captures the answer burst
// and drains it downstream. Build option FENCE_HOST_TIMEOUT_EN adds a WAIT-state timeout.
module fence_host import fence_pkg::*; #(
   parameter int NPTS     = NPTS_DEF,
   parameter int W        = W_DEF,
   parameter int RSP_SKIP = 1,
   parameter int TIMEOUT  = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [W-1:0] load_x,
   input  logic [W-1:0] load_y,
   output logic         give_valid,
   output logic [W-1:0] dataX,
   output logic [W-1:0] dataY,
   input  logic         out_valid,
   input  logic [W-1:0] ansX,
   input  logic [W-1:0] ansY,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic [W-1:0] rd_x,
   output logic [W-1:0] rd_y,
   output logic         busy,
   output logic         timeout_err,
   output logic [2:0]   state_dbg
);

   localparam int IW = $clog2(NPTS + 1);

   // The buffer read path relies on entry 0 being written before the last load, and the
   // WAIT skip count shares idx, so these bounds must hold.
   if (NPTS < 2 || RSP_SKIP < 1 || RSP_SKIP > NPTS || TIMEOUT < 1) begin : g_bad_cfg
      $error("fence_host: unsupported parameter set");
   end

   logic [2:0]    state;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_inc;
   logic          last_idx;
   logic          load_fire;
   logic          timeout_hit;
   logic [IW-1:0] buf_raddr;
   logic [IW-1:0] res_raddr;
   logic [W-1:0]  buf_rx, buf_ry;
   logic [W-1:0]  res_rx, res_ry;

   assign idx_inc   = idx + IW'(1);
   assign last_idx  = (idx == IW'(NPTS - 1));
   assign state_dbg = state;

   // Both handshakes transfer on a cycle where valid && ready are high at the rising edge;
   // a valid side holds its data stable until that edge, and ready never depends on valid.
   assign load_fire = load_valid && load_ready;

   // Outputs are registered, so each read looks one entry ahead of the value on the pins.
   assign buf_raddr = (state == S_SEND)  ? idx_inc : '0;
   assign res_raddr = (state == S_DRAIN) ? idx_inc : '0;

   fence_pt_buf #(.DEPTH(NPTS), .W(W), .AW(IW)) u_buf (
      .clk   (clk),
      .reset (reset),
      .we    (load_fire),
      .waddr (idx),
      .wx    (load_x),
      .wy    (load_y),
      .raddr (buf_raddr),
      .rx    (buf_rx),
      .ry    (buf_ry)
   );

   fence_pt_buf #(.DEPTH(NPTS), .W(W), .AW(IW)) u_res (
      .clk   (clk),
      .reset (reset),
      .we    (state == S_CAPT),
      .waddr (idx),
      .wx    (ansX),
      .wy    (ansY),
      .raddr (res_raddr),
      .rx    (res_rx),
      .ry    (res_ry)
   );

`ifdef FENCE_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer;

   // Only the silence before the first out_valid counts towards the timeout.
   assign timeout_hit = (state == S_WAIT) && (idx == '0) && !out_valid &&
                        (timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer       <= '0;
         timeout_err <= 1'b0;
      end else begin
         if ((state == S_WAIT) && (idx == '0) && !out_valid) timer <= timer + TW'(1);
         else if (state != S_WAIT)                           timer <= '0;
         if (load_fire)        timeout_err <= 1'b0;
         else if (timeout_hit) timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_LOAD;
         idx        <= '0;
         load_ready <= 1'b1;
         give_valid <= 1'b0;
         dataX      <= '0;
         dataY      <= '0;
         rd_valid   <= 1'b0;
         rd_x       <= '0;
         rd_y       <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (load_fire) begin
                  if (last_idx) begin
                     state      <= S_SEND;
                     idx        <= '0;
                     load_ready <= 1'b0;
                     busy       <= 1'b1;
                     give_valid <= 1'b1;
                     dataX      <= buf_rx;
                     dataY      <= buf_ry;
                  end else begin
                     idx <= idx_inc;
                  end
               end
            end
            S_SEND: begin
               if (last_idx) begin
                  state      <= S_WAIT;
                  idx        <= '0;
                  give_valid <= 1'b0;
               end else begin
                  idx   <= idx_inc;
                  dataX <= buf_rx;
                  dataY <= buf_ry;
               end
            end
            S_WAIT: begin
               if (timeout_hit) begin
                  state      <= S_LOAD;
                  idx        <= '0;
                  load_ready <= 1'b1;
                  busy       <= 1'b0;
               end else if (out_valid) begin
                  if (idx == IW'(RSP_SKIP - 1)) begin
                     state <= S_CAPT;
                     idx   <= '0;
                  end else begin
                     idx <= idx_inc;
                  end
               end
            end
            S_CAPT: begin
               if (last_idx) begin
                  state    <= S_DRAIN;
                  idx      <= '0;
                  rd_valid <= 1'b1;
                  rd_x     <= res_rx;
                  rd_y     <= res_ry;
               end else begin
                  idx <= idx_inc;
               end
            end
            S_DRAIN: begin
               if (rd_valid && rd_ready) begin
                  if (last_idx) begin
                     state      <= S_LOAD;
                     idx        <= '0;
                     rd_valid   <= 1'b0;
                     load_ready <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     idx  <= idx_inc;
                     rd_x <= res_rx;
                     rd_y <= res_ry;
                  end
               end
            end
            default: begin
               state      <= S_LOAD;
               idx        <= '0;
               load_ready <= 1'b1;
               give_valid <= 1'b0;
               rd_valid   <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fence_host.sv
// Self-checking bench for fence_host: frame load, engine stream, answer capture and drain,
// plus reset abort, ignored loads and the WAIT timeout (FENCE_HOST_TIMEOUT_EN) or hold.
`timescale 1ns/1ps
module tb_fence_host;
   import fence_pkg::*;

   localparam int NPTS     = 6;
   localparam int W        = 8;
   localparam int RSP_SKIP = 1;
`ifdef FENCE_HOST_TIMEOUT_EN
   localparam int TIMEOUT  = 20;
`else
   localparam int TIMEOUT  = 255;
`endif

   logic         clk, reset;
   logic         load_valid, load_ready;
   logic [W-1:0] load_x, load_y;
   logic         give_valid;
   logic [W-1:0] dataX, dataY;
   logic         out_valid;
   logic [W-1:0] ansX, ansY;
   logic         rd_valid, rd_ready;
   logic [W-1:0] rd_x, rd_y;
   logic         busy, timeout_err;
   logic [2:0]   state_dbg;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];

   fence_host #(.NPTS(NPTS), .W(W), .RSP_SKIP(RSP_SKIP), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_x      (load_x),
      .load_y      (load_y),
      .give_valid  (give_valid),
      .dataX       (dataX),
      .dataY       (dataY),
      .out_valid   (out_valid),
      .ansX        (ansX),
      .ansY        (ansY),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .busy        (busy),
      .timeout_err (timeout_err),
      .state_dbg   (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      reset      = 1'b0;
      load_valid = 1'b0;
      load_x     = '0;
      load_y     = '0;
      out_valid  = 1'b0;
      ansX       = '0;
      ansY       = '0;
      rd_ready   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_load(input logic [W-1:0] xs [NPTS], input logic [W-1:0] ys [NPTS]);
      for (int i = 0; i < NPTS; i++) begin
         @(negedge clk);
         checks++;
         if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_pt%0d: got %b want 1", i, load_ready);
         end
         load_valid = 1'b1;
         load_x     = xs[i];
         load_y     = ys[i];
         exp_q.push_back({xs[i], ys[i]});
      end
   endtask

   // Observes the give_valid stream; returns at the first WAIT-cycle negedge.
   task automatic collect_send(input bit hold);
      int n;
      logic [2*W-1:0] e;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (give_valid) begin
            if (n == 0) begin
               checks++;
               if (load_ready !== 1'b0 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL send_flags: load_ready=%b busy=%b want 0/1", load_ready, busy);
               end
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL send_extra: got %0d,%0d with nothing expected", dataX, dataY);
            end else begin
               e = exp_q.pop_front();
               if ({dataX, dataY} !== e) begin
                  errors++;
                  $display("FAIL send_data%0d: got %0d,%0d want %0d,%0d", n, dataX, dataY,
                           e[2*W-1:W], e[W-1:0]);
               end
            end
            n++;
         end else if (n > 0) begin
            break;
         end
         if (hold) begin
            load_x = W'($urandom_range(0, 255));
            load_y = W'($urandom_range(0, 255));
         end else begin
            load_valid = 1'b0;
         end
      end
      checks++;
      if (n != NPTS || exp_q.size() != 0) begin
         errors++;
         $display("FAIL send_count: got %0d beats (%0d left) want %0d", n, exp_q.size(), NPTS);
      end
   endtask

   // Engine model: one skipped out_valid cycle, NPTS answer cycles, one trailing cycle.
   task automatic engine_burst(input logic [W-1:0] ax [NPTS], input logic [W-1:0] ay [NPTS]);
      out_valid = 1'b1;
      ansX      = 8'hA5;
      ansY      = 8'h5A;
      for (int i = 0; i < NPTS; i++) begin
         @(negedge clk);
         ansX = ax[i];
         ansY = ay[i];
         exp_q.push_back({ax[i], ay[i]});
      end
      @(negedge clk);
      ansX = 8'h33;
      ansY = 8'hCC;
      @(negedge clk);
      out_valid = 1'b0;
      ansX      = '0;
      ansY      = '0;
   endtask

   // ---------------- scoreboard: drain side ----------------
   task automatic collect_drain(input bit toggle);
      bit pv, pr;
      logic [2*W-1:0] pd, e;
      int hs;
      pv = 1'b0; pr = 1'b0; pd = '0; hs = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (pv && pr) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL drain_extra: got %0d,%0d with nothing expected", pd[2*W-1:W], pd[W-1:0]);
            end else begin
               e = exp_q.pop_front();
               if (pd !== e) begin
                  errors++;
                  $display("FAIL drain_data%0d: got %0d,%0d want %0d,%0d", hs, pd[2*W-1:W],
                           pd[W-1:0], e[2*W-1:W], e[W-1:0]);
               end
            end
            hs++;
         end else if (pv) begin
            checks++;
            if (rd_valid !== 1'b1 || {rd_x, rd_y} !== pd) begin
               errors++;
               $display("FAIL drain_stall: got v=%b %0d,%0d want v=1 %0d,%0d", rd_valid, rd_x, rd_y,
                        pd[2*W-1:W], pd[W-1:0]);
            end
         end
         if (hs == NPTS) break;
         pv       = rd_valid;
         pd       = {rd_x, rd_y};
         rd_ready = toggle ? ~rd_ready : 1'b1;
         pr       = rd_ready;
      end
      checks++;
      if (hs != NPTS || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_count: got %0d handshakes (%0d left) want %0d", hs, exp_q.size(), NPTS);
      end
      checks++;
      if (rd_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || state_dbg !== S_LOAD) begin
         errors++;
         $display("FAIL drain_end: got v=%b lr=%b busy=%b st=%0d want 0/1/0/%0d", rd_valid,
                  load_ready, busy, state_dbg, S_LOAD);
      end
      rd_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got rd_valid=%b want 0", rd_valid);
         end
      end
      rd_ready = 1'b0;
   endtask

   task automatic run_random_frame(input bit toggle);
      logic [W-1:0] xs [NPTS], ys [NPTS], ax [NPTS], ay [NPTS];
      for (int i = 0; i < NPTS; i++) begin
         xs[i] = W'($urandom_range(0, 255));
         ys[i] = W'($urandom_range(0, 255));
         ax[i] = W'($urandom_range(0, 255));
         ay[i] = W'($urandom_range(0, 255));
      end
      do_load(xs, ys);
      collect_send(1'b0);
      engine_burst(ax, ay);
      collect_drain(toggle);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0;
      load_valid = 1'b0; load_x = '0; load_y = '0;
      out_valid = 1'b0; ansX = '0; ansY = '0; rd_ready = 1'b0;
      #12;
      checks++;
      if (load_ready !== 1'b1 || give_valid !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0 ||
          timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got lr=%b gv=%b rv=%b busy=%b to=%b want 1/0/0/0/0",
                  load_ready, give_valid, rd_valid, busy, timeout_err);
      end
      checks++;
      if ({dataX, dataY, rd_x, rd_y} !== '0 || state_dbg !== S_LOAD) begin
         errors++;
         $display("FAIL reset_data: got %h st=%0d want 0 st=%0d", {dataX, dataY, rd_x, rd_y},
                  state_dbg, S_LOAD);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b1 || busy !== 1'b0 || state_dbg !== S_LOAD) begin
         errors++;
         $display("FAIL reset_release: got lr=%b busy=%b st=%0d want 1/0/%0d", load_ready, busy,
                  state_dbg, S_LOAD);
      end
   endtask

   task automatic test_basic_frame();
      logic [W-1:0] xs [NPTS], ys [NPTS], ax [NPTS], ay [NPTS];
      xs = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9, 8'd11};
      ys = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12};
      ax = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8, 8'd10};
      ay = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8, 8'd10};
      exp_q.delete();
      do_load(xs, ys);
      collect_send(1'b0);
      engine_burst(ax, ay);
      collect_drain(1'b0);
   endtask

   task automatic test_rd_stall();
      exp_q.delete();
      run_random_frame(1'b1);
   endtask

   task automatic test_reset_mid_send();
      logic [W-1:0] xs [NPTS], ys [NPTS];
      int n;
      for (int i = 0; i < NPTS; i++) begin
         xs[i] = W'($urandom_range(1, 255));
         ys[i] = W'($urandom_range(1, 255));
      end
      exp_q.delete();
      do_load(xs, ys);
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         @(negedge clk);
         load_valid = 1'b0;
         if (give_valid) n++;
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL abort_reach: got %0d send cycles want 3", n);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (give_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || state_dbg !== S_LOAD) begin
         errors++;
         $display("FAIL abort_flags: got gv=%b lr=%b busy=%b st=%0d want 0/1/0/%0d", give_valid,
                  load_ready, busy, state_dbg, S_LOAD);
      end
      checks++;
      if ({dataX, dataY} !== '0) begin
         errors++;
         $display("FAIL abort_data: got %0d,%0d want 0,0", dataX, dataY);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      rd_ready = 1'b1;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (rd_valid || give_valid) n++;
      end
      rd_ready = 1'b0;
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL abort_quiet: got %0d active cycles want 0", n);
      end
   endtask

   task automatic test_load_ignored();
      logic [W-1:0] xs [NPTS], ys [NPTS], ax [NPTS], ay [NPTS];
      for (int i = 0; i < NPTS; i++) begin
         xs[i] = W'(8'h10 + i);
         ys[i] = W'(8'hE0 + i);
         ax[i] = W'($urandom_range(0, 255));
         ay[i] = W'($urandom_range(0, 255));
      end
      exp_q.delete();
      do_load(xs, ys);
      collect_send(1'b1);
      engine_burst(ax, ay);
      load_valid = 1'b0;
      collect_drain(1'b0);
      run_random_frame(1'b0);
   endtask

   task automatic test_timeout();
      logic [W-1:0] xs [NPTS], ys [NPTS];
      int n;
      for (int i = 0; i < NPTS; i++) begin
         xs[i] = W'($urandom_range(0, 255));
         ys[i] = W'($urandom_range(0, 255));
      end
      exp_q.delete();
      do_load(xs, ys);
      collect_send(1'b0);
      out_valid = 1'b0;
      rd_ready  = 1'b1;
`ifdef FENCE_HOST_TIMEOUT_EN
      n = 0;
      for (int c = 0; c < 100; c++) begin
         if (timeout_err) break;
         if (state_dbg == S_WAIT) n++;
         @(negedge clk);
      end
      checks++;
      if (n != TIMEOUT) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d WAIT cycles want %0d", n, TIMEOUT);
      end
      checks++;
      if (timeout_err !== 1'b1 || state_dbg !== S_LOAD || load_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flags: got to=%b st=%0d lr=%b busy=%b want 1/%0d/1/0", timeout_err,
                  state_dbg, load_ready, busy, S_LOAD);
      end
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (rd_valid !== 1'b0 || timeout_err !== 1'b1) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL timeout_hold: got %0d bad cycles want 0", n);
      end
      rd_ready = 1'b0;
`else
      n = 0;
      repeat (300) begin
         @(negedge clk);
         if (state_dbg !== S_WAIT || busy !== 1'b1 || rd_valid !== 1'b0 || timeout_err !== 1'b0) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL wait_hold: got %0d cycles out of WAIT want 0", n);
      end
      apply_reset();
`endif
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] xs [NPTS], ys [NPTS], ax [NPTS], ay [NPTS];
      for (int i = 0; i < NPTS; i++) begin
         xs[i] = W'($urandom_range(0, 255));
         ys[i] = W'($urandom_range(0, 255));
         ax[i] = W'($urandom_range(128, 255));
         ay[i] = W'($urandom_range(0, 127));
      end
      exp_q.delete();
      do_load(xs, ys);
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got timeout_err=%b want 0", timeout_err);
      end
      collect_send(1'b0);
      engine_burst(ax, ay);
      collect_drain(1'b0);
      run_random_frame(1'b1);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic_frame();
      test_rd_stall();
      test_reset_mid_send();
      test_load_ignored();
      test_timeout();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
